// File: rtl/cpu_axi_bridge_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_axi_bridge_if
// Description : Bundles the CPU sram-like instruction/data ports and the single
//               AXI3 master port of cpu_axi_bridge. The "master" modport is the
//               bridge's view: it masters AXI and answers the two sram ports.
//               The "slave" modport is the environment's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu_axi_bridge_if;
  // Instruction sram-like port
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  // Data sram-like port
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  // AXI read address channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  // AXI read data channel
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  // AXI write address channel
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  // AXI write data channel
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  // AXI write response channel
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    input  inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    output inst_req, inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface
`default_nettype wire

// File: rtl/cpu_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : cpu_axi_bridge
// Description : Arbitrates the CPU instruction and data sram-like ports (data
//               has priority) and turns each accepted request into one
//               single-beat AXI3 read or write. One transaction in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_axi_bridge (
  input  logic              clk,
  input  logic              resetn,
  cpu_axi_bridge_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW_W = 3'd3,
    S_B    = 3'd4,
    S_RESP = 3'd5
  } state_t;

  state_t      r_state;
  logic [1:0]  r_size;
  logic [3:0]  r_wstrb;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_src;          // 0 = inst, 1 = data
  logic        r_arvalid;
  logic        r_rready;
  logic        r_awvalid;      // low once the AW handshake is done
  logic        r_wvalid;       // low once the W handshake is done
  logic        r_bready;
  logic        r_inst_data_ok;
  logic        r_data_data_ok;

  logic        w_idle;
  logic        w_grant_data;
  logic        w_grant_inst;
  logic        w_accept;
  logic        w_req_wr;
  logic [1:0]  w_req_size;
  logic [3:0]  w_req_wstrb;
  logic [31:0] w_req_addr;
  logic [31:0] w_req_wdata;
  logic        w_aw_done;
  logic        w_w_done;

  // addr_ok is gated by resetn so nothing is granted while reset is asserted
  assign w_idle       = resetn && (r_state == S_IDLE);
  assign w_grant_data = w_idle && bus.data_req;
  assign w_grant_inst = w_idle && !bus.data_req && bus.inst_req;
  assign w_accept     = w_grant_data || w_grant_inst;

  assign w_req_wr    = w_grant_data ? bus.data_wr    : bus.inst_wr;
  assign w_req_size  = w_grant_data ? bus.data_size  : bus.inst_size;
  assign w_req_wstrb = w_grant_data ? bus.data_wstrb : bus.inst_wstrb;
  assign w_req_addr  = w_grant_data ? bus.data_addr  : bus.inst_addr;
  assign w_req_wdata = w_grant_data ? bus.data_wdata : bus.inst_wdata;

  // A channel counts as done if it already handshook or handshakes this cycle
  assign w_aw_done = !r_awvalid || bus.awready;
  assign w_w_done  = !r_wvalid  || bus.wready;

  // Transaction FSM with registered channel valids/readies and data_ok pulses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= S_IDLE;
      r_size         <= 2'd0;
      r_wstrb        <= 4'd0;
      r_addr         <= 32'd0;
      r_wdata        <= 32'd0;
      r_rdata        <= 32'd0;
      r_src          <= 1'b0;
      r_arvalid      <= 1'b0;
      r_rready       <= 1'b0;
      r_awvalid      <= 1'b0;
      r_wvalid       <= 1'b0;
      r_bready       <= 1'b0;
      r_inst_data_ok <= 1'b0;
      r_data_data_ok <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_size  <= w_req_size;
            r_wstrb <= w_req_wstrb;
            r_addr  <= w_req_addr;
            r_wdata <= w_req_wdata;
            r_src   <= w_grant_data;
            if (w_req_wr) begin
              r_state   <= S_AW_W;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_state   <= S_AR;
              r_arvalid <= 1'b1;
            end
          end
        end
        S_AR: begin
          if (bus.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_R;
          end
        end
        S_R: begin
          if (bus.rvalid) begin
            r_rready       <= 1'b0;
            r_rdata        <= bus.rdata;
            r_inst_data_ok <= !r_src;
            r_data_data_ok <= r_src;
            r_state        <= S_RESP;
          end
        end
        S_AW_W: begin
          if (bus.awready) r_awvalid <= 1'b0;
          if (bus.wready)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= S_B;
          end
        end
        S_B: begin
          if (bus.bvalid) begin
            r_bready       <= 1'b0;
            r_inst_data_ok <= !r_src;
            r_data_data_ok <= r_src;
            r_state        <= S_RESP;
          end
        end
        S_RESP: begin
          r_inst_data_ok <= 1'b0;
          r_data_data_ok <= 1'b0;
          r_state        <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // sram-like side
  assign bus.inst_addr_ok = w_grant_inst;
  assign bus.data_addr_ok = w_grant_data;
  assign bus.inst_data_ok = r_inst_data_ok;
  assign bus.data_data_ok = r_data_data_ok;
  assign bus.inst_rdata   = r_rdata;
  assign bus.data_rdata   = r_rdata;

  // AXI read address / data
  assign bus.arid    = {3'b000, r_src};
  assign bus.araddr  = r_addr;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = {1'b0, r_size};
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'd0;
  assign bus.arprot  = 3'd0;
  assign bus.arvalid = r_arvalid;
  assign bus.rready  = r_rready;

  // AXI write address / data / response
  assign bus.awid    = 4'd1;
  assign bus.awaddr  = r_addr;
  assign bus.awlen   = 8'd0;
  assign bus.awsize  = {1'b0, r_size};
  assign bus.awburst = 2'b01;
  assign bus.awlock  = 2'b00;
  assign bus.awcache = 4'd0;
  assign bus.awprot  = 3'd0;
  assign bus.awvalid = r_awvalid;
  assign bus.wid     = 4'd1;
  assign bus.wdata   = r_wdata;
  assign bus.wstrb   = r_wstrb;
  assign bus.wlast   = 1'b1;
  assign bus.wvalid  = r_wvalid;
  assign bus.bready  = r_bready;

endmodule
`default_nettype wire

// File: tb/tb_cpu_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_axi_bridge
// Description : Directed self-checking bench for cpu_axi_bridge. Inputs change
//               1ns after the rising edge, outputs are checked on the falling
//               edge. "Cycle N" counts from the cycle in which addr_ok is high.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_axi_bridge;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_fail;

  cpu_axi_bridge_if bus ();

  cpu_axi_bridge dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so the run can never hang
  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "timeout");
  end

  // Advance to just after the next rising edge, where inputs are driven
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.inst_req = 0; bus.inst_wr = 0; bus.inst_size = 0; bus.inst_wstrb = 0;
    bus.inst_addr = 0; bus.inst_wdata = 0;
    bus.data_req = 0; bus.data_wr = 0; bus.data_size = 0; bus.data_wstrb = 0;
    bus.data_addr = 0; bus.data_wdata = 0;
    bus.arready = 0; bus.rid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0; bus.rvalid = 0;
    bus.awready = 0; bus.wready = 0; bus.bid = 0; bus.bresp = 0; bus.bvalid = 0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clear_inputs();
    bus.inst_req = 1; bus.data_req = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.inst_addr_ok !== 1'b0 || bus.data_addr_ok !== 1'b0) begin n_fail++; $display("FAIL reset_addr_ok: got inst=%b data=%b want 0/0", bus.inst_addr_ok, bus.data_addr_ok); end
    n_checks++; if (bus.inst_data_ok !== 1'b0 || bus.data_data_ok !== 1'b0) begin n_fail++; $display("FAIL reset_data_ok: got inst=%b data=%b want 0/0", bus.inst_data_ok, bus.data_data_ok); end
    n_checks++; if ({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready} !== 5'b0) begin n_fail++; $display("FAIL reset_axi_handshake: got ar/r/aw/w/b=%b want 00000", {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready}); end
    n_checks++; if (bus.inst_rdata !== 32'h0 || bus.data_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 0", bus.inst_rdata, bus.data_rdata); end
    next_cycle();
    bus.inst_req = 0; bus.data_req = 0;
    resetn = 1'b1;
    next_cycle();
  endtask

  task automatic test_inst_read();
    // cycle 0: request presented and accepted
    bus.inst_req = 1; bus.inst_wr = 0; bus.inst_size = 2; bus.inst_addr = 32'h1C00_0000;
    bus.arready = 1;
    @(negedge clk);
    n_checks++; if (bus.inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL rd_addr_ok: got %b want 1", bus.inst_addr_ok); end
    // cycle 1: AR
    next_cycle();
    bus.inst_req = 0;
    @(negedge clk);
    n_checks++; if (bus.arvalid !== 1'b1) begin n_fail++; $display("FAIL rd_arvalid: got %b want 1", bus.arvalid); end
    n_checks++; if (bus.arid !== 4'd0 || bus.arsize !== 3'd2 || bus.arlen !== 8'd0) begin n_fail++; $display("FAIL rd_ar_fields: got id=%h size=%h len=%h want 0/2/0", bus.arid, bus.arsize, bus.arlen); end
    n_checks++; if (bus.araddr !== 32'h1C00_0000 || bus.arburst !== 2'b01) begin n_fail++; $display("FAIL rd_araddr: got %h burst=%b want 1c000000/01", bus.araddr, bus.arburst); end
    // cycle 2: R with rvalid
    next_cycle();
    bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'h0280_0C0C; bus.rid = 4'hF; bus.rresp = 2'b11;
    @(negedge clk);
    n_checks++; if (bus.rready !== 1'b1 || bus.inst_data_ok !== 1'b0) begin n_fail++; $display("FAIL rd_r_state: got rready=%b data_ok=%b want 1/0", bus.rready, bus.inst_data_ok); end
    // cycle 3: response
    next_cycle();
    bus.rvalid = 0; bus.rdata = 0; bus.rid = 0; bus.rresp = 0;
    @(negedge clk);
    n_checks++; if (bus.inst_data_ok !== 1'b1 || bus.data_data_ok !== 1'b0) begin n_fail++; $display("FAIL rd_data_ok: got inst=%b data=%b want 1/0", bus.inst_data_ok, bus.data_data_ok); end
    n_checks++; if (bus.inst_rdata !== 32'h0280_0C0C) begin n_fail++; $display("FAIL rd_rdata: got %h want 02800c0c", bus.inst_rdata); end
    n_checks++; if (bus.rready !== 1'b0) begin n_fail++; $display("FAIL rd_rready_resp: got %b want 0", bus.rready); end
    // cycle 4: pulse is exactly one cycle
    next_cycle();
    @(negedge clk);
    n_checks++; if (bus.inst_data_ok !== 1'b0) begin n_fail++; $display("FAIL rd_data_ok_pulse: got %b want 0", bus.inst_data_ok); end
    n_checks++; if (bus.inst_rdata !== 32'h0280_0C0C) begin n_fail++; $display("FAIL rd_rdata_hold: got %h want 02800c0c", bus.inst_rdata); end
    next_cycle();
  endtask

  task automatic test_simultaneous();
    // cycle 0: both ports request, data wins
    bus.inst_req = 1; bus.inst_wr = 0; bus.inst_size = 2; bus.inst_addr = 32'h1C00_0004;
    bus.data_req = 1; bus.data_wr = 0; bus.data_size = 2; bus.data_addr = 32'h0000_1000;
    bus.arready = 1;
    @(negedge clk);
    n_checks++; if (bus.data_addr_ok !== 1'b1 || bus.inst_addr_ok !== 1'b0) begin n_fail++; $display("FAIL sim_grant: got data=%b inst=%b want 1/0", bus.data_addr_ok, bus.inst_addr_ok); end
    // cycle 1: data AR; inst_req still held
    next_cycle();
    bus.data_req = 0;
    @(negedge clk);
    n_checks++; if (bus.arvalid !== 1'b1 || bus.arid !== 4'd1 || bus.araddr !== 32'h0000_1000) begin n_fail++; $display("FAIL sim_data_ar: got v=%b id=%h addr=%h want 1/1/00001000", bus.arvalid, bus.arid, bus.araddr); end
    n_checks++; if (bus.inst_addr_ok !== 1'b0) begin n_fail++; $display("FAIL sim_busy_addr_ok: got %b want 0", bus.inst_addr_ok); end
    // cycle 2: R
    next_cycle();
    bus.rvalid = 1; bus.rdata = 32'h1111_1111;
    // cycle 3: data response
    next_cycle();
    bus.rvalid = 0;
    @(negedge clk);
    n_checks++; if (bus.data_data_ok !== 1'b1 || bus.inst_data_ok !== 1'b0 || bus.data_rdata !== 32'h1111_1111) begin n_fail++; $display("FAIL sim_data_resp: got ok d=%b i=%b rdata=%h want 1/0/11111111", bus.data_data_ok, bus.inst_data_ok, bus.data_rdata); end
    n_checks++; if (bus.inst_addr_ok !== 1'b0) begin n_fail++; $display("FAIL sim_resp_addr_ok: got %b want 0", bus.inst_addr_ok); end
    // cycle 4: back in IDLE, held inst request granted
    next_cycle();
    @(negedge clk);
    n_checks++; if (bus.inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL sim_inst_grant: got %b want 1", bus.inst_addr_ok); end
    // cycle 5: inst AR
    next_cycle();
    bus.inst_req = 0;
    @(negedge clk);
    n_checks++; if (bus.arvalid !== 1'b1 || bus.arid !== 4'd0 || bus.araddr !== 32'h1C00_0004) begin n_fail++; $display("FAIL sim_inst_ar: got v=%b id=%h addr=%h want 1/0/1c000004", bus.arvalid, bus.arid, bus.araddr); end
    // cycle 6: R, cycle 7: inst response
    next_cycle();
    bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'h2222_2222;
    next_cycle();
    bus.rvalid = 0;
    @(negedge clk);
    n_checks++; if (bus.inst_data_ok !== 1'b1 || bus.data_data_ok !== 1'b0 || bus.inst_rdata !== 32'h2222_2222) begin n_fail++; $display("FAIL sim_inst_resp: got ok i=%b d=%b rdata=%h want 1/0/22222222", bus.inst_data_ok, bus.data_data_ok, bus.inst_rdata); end
    next_cycle();
  endtask

  task automatic test_split_write();
    // cycle 0: data write accepted
    bus.data_req = 1; bus.data_wr = 1; bus.data_size = 1; bus.data_wstrb = 4'h3;
    bus.data_addr = 32'h0000_2000; bus.data_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++; if (bus.data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL wr_addr_ok: got %b want 1", bus.data_addr_ok); end
    // cycle 1: AW_W, only wready high
    next_cycle();
    bus.data_req = 0; bus.data_wdata = 0; bus.data_addr = 0; bus.data_wstrb = 0;
    bus.wready = 1;
    @(negedge clk);
    n_checks++; if (bus.awvalid !== 1'b1 || bus.wvalid !== 1'b1) begin n_fail++; $display("FAIL wr_valids: got aw=%b w=%b want 1/1", bus.awvalid, bus.wvalid); end
    n_checks++; if (bus.awsize !== 3'd1 || bus.wstrb !== 4'h3 || bus.wlast !== 1'b1 || bus.awlen !== 8'd0) begin n_fail++; $display("FAIL wr_fields: got size=%h strb=%h last=%b len=%h want 1/3/1/0", bus.awsize, bus.wstrb, bus.wlast, bus.awlen); end
    n_checks++; if (bus.awaddr !== 32'h0000_2000 || bus.wdata !== 32'hDEAD_BEEF || bus.awid !== 4'd1 || bus.wid !== 4'd1) begin n_fail++; $display("FAIL wr_addr_data: got addr=%h data=%h awid=%h wid=%h want 00002000/deadbeef/1/1", bus.awaddr, bus.wdata, bus.awid, bus.wid); end
    // cycles 2..4: W done, AW still waiting; awready arrives in cycle 4
    for (int i = 2; i <= 4; i++) begin
      next_cycle();
      bus.wready = 0;
      bus.awready = (i == 4);
      @(negedge clk);
      n_checks++; if (bus.wvalid !== 1'b0 || bus.awvalid !== 1'b1 || bus.bready !== 1'b0) begin n_fail++; $display("FAIL wr_split_c%0d: got w=%b aw=%b bready=%b want 0/1/0", i, bus.wvalid, bus.awvalid, bus.bready); end
      n_checks++; if (bus.awaddr !== 32'h0000_2000) begin n_fail++; $display("FAIL wr_awaddr_stable_c%0d: got %h want 00002000", i, bus.awaddr); end
    end
    // cycle 5: B
    next_cycle();
    bus.awready = 0; bus.bvalid = 1; bus.bresp = 2'b10;
    @(negedge clk);
    n_checks++; if (bus.bready !== 1'b1 || bus.awvalid !== 1'b0 || bus.data_data_ok !== 1'b0) begin n_fail++; $display("FAIL wr_b_state: got bready=%b aw=%b ok=%b want 1/0/0", bus.bready, bus.awvalid, bus.data_data_ok); end
    // cycle 6: response
    next_cycle();
    bus.bvalid = 0; bus.bresp = 0;
    @(negedge clk);
    n_checks++; if (bus.data_data_ok !== 1'b1 || bus.inst_data_ok !== 1'b0 || bus.bready !== 1'b0) begin n_fail++; $display("FAIL wr_resp: got d=%b i=%b bready=%b want 1/0/0", bus.data_data_ok, bus.inst_data_ok, bus.bready); end
    // cycle 7: single pulse
    next_cycle();
    @(negedge clk);
    n_checks++; if (bus.data_data_ok !== 1'b0) begin n_fail++; $display("FAIL wr_pulse: got %b want 0", bus.data_data_ok); end
    next_cycle();
  endtask

  task automatic test_stalls();
    // cycle 0: inst read accepted
    bus.inst_req = 1; bus.inst_wr = 0; bus.inst_size = 2; bus.inst_addr = 32'h1C00_0010;
    bus.arready = 0;
    @(negedge clk);
    n_checks++; if (bus.inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL stall_addr_ok: got %b want 1", bus.inst_addr_ok); end
    // cycles 1..6: arvalid held, arready rises in cycle 6
    for (int i = 1; i <= 6; i++) begin
      next_cycle();
      bus.inst_req = 0; bus.inst_addr = 32'hFFFF_FFFF;
      bus.arready = (i == 6);
      @(negedge clk);
      n_checks++; if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h1C00_0010 || bus.rready !== 1'b0) begin n_fail++; $display("FAIL stall_ar_c%0d: got v=%b addr=%h rready=%b want 1/1c000010/0", i, bus.arvalid, bus.araddr, bus.rready); end
    end
    // cycles 7..10: in R, no rvalid yet
    for (int i = 7; i <= 10; i++) begin
      next_cycle();
      bus.arready = 0;
      @(negedge clk);
      n_checks++; if (bus.rready !== 1'b1 || bus.arvalid !== 1'b0 || bus.inst_data_ok !== 1'b0) begin n_fail++; $display("FAIL stall_r_c%0d: got rready=%b arv=%b ok=%b want 1/0/0", i, bus.rready, bus.arvalid, bus.inst_data_ok); end
    end
    // cycle 11: rvalid, cycle 12: response
    next_cycle();
    bus.rvalid = 1; bus.rdata = 32'hCAFE_F00D;
    next_cycle();
    bus.rvalid = 0;
    @(negedge clk);
    n_checks++; if (bus.inst_data_ok !== 1'b1 || bus.rready !== 1'b0 || bus.inst_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL stall_resp: got ok=%b rready=%b rdata=%h want 1/0/cafef00d", bus.inst_data_ok, bus.rready, bus.inst_rdata); end
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    // cycle 0 accept, cycle 1 AR, cycle 2 R (no rvalid)
    bus.inst_req = 1; bus.inst_wr = 0; bus.inst_size = 2; bus.inst_addr = 32'h1C00_0020;
    bus.arready = 1;
    next_cycle();
    bus.inst_req = 0;
    next_cycle();
    bus.arready = 0;
    @(negedge clk);
    n_checks++; if (bus.rready !== 1'b1) begin n_fail++; $display("FAIL rst_pre_rready: got %b want 1", bus.rready); end
    // assert reset mid-cycle with requests pending
    #1;
    bus.inst_req = 1; bus.data_req = 1;
    resetn = 1'b0;
    #1;
    n_checks++; if (bus.rready !== 1'b0 || bus.arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_async_axi: got rready=%b arvalid=%b want 0/0", bus.rready, bus.arvalid); end
    n_checks++; if (bus.inst_data_ok !== 1'b0 || bus.data_data_ok !== 1'b0) begin n_fail++; $display("FAIL rst_async_data_ok: got %b/%b want 0/0", bus.inst_data_ok, bus.data_data_ok); end
    n_checks++; if (bus.inst_addr_ok !== 1'b0 || bus.data_addr_ok !== 1'b0) begin n_fail++; $display("FAIL rst_gate_addr_ok: got %b/%b want 0/0", bus.inst_addr_ok, bus.data_addr_ok); end
    bus.rvalid = 1; bus.rdata = 32'hBAD0_BAD0;
    next_cycle();
    @(negedge clk);
    n_checks++; if (bus.inst_data_ok !== 1'b0 || bus.inst_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_no_resp: got ok=%b rdata=%h want 0/0", bus.inst_data_ok, bus.inst_rdata); end
    next_cycle();
    bus.rvalid = 0; bus.rdata = 0; bus.data_req = 0;
    resetn = 1'b1;
    // new inst read from IDLE completes in the minimum 4 cycles
    bus.inst_addr = 32'h1C00_0030; bus.arready = 1;
    @(negedge clk);
    n_checks++; if (bus.inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL rst_idle_grant: got %b want 1", bus.inst_addr_ok); end
    next_cycle();
    bus.inst_req = 0;
    @(negedge clk);
    n_checks++; if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h1C00_0030) begin n_fail++; $display("FAIL rst_new_ar: got v=%b addr=%h want 1/1c000030", bus.arvalid, bus.araddr); end
    next_cycle();
    bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'h1357_2468;
    next_cycle();
    bus.rvalid = 0;
    @(negedge clk);
    n_checks++; if (bus.inst_data_ok !== 1'b1 || bus.inst_rdata !== 32'h1357_2468) begin n_fail++; $display("FAIL rst_new_resp: got ok=%b rdata=%h want 1/13572468", bus.inst_data_ok, bus.inst_rdata); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    // data read then data write with data_req held continuously
    bus.data_req = 1; bus.data_wr = 0; bus.data_size = 2; bus.data_addr = 32'h0000_3000;
    bus.arready = 1; bus.rvalid = 1; bus.rdata = 32'hA5A5_0001;
    bus.awready = 1; bus.wready = 1; bus.bvalid = 1;
    @(negedge clk);
    n_checks++; if (bus.data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL b2b_first_grant: got %b want 1", bus.data_addr_ok); end
    next_cycle();
    bus.data_wr = 1; bus.data_addr = 32'h0000_3004; bus.data_wdata = 32'h0BAD_F00D; bus.data_wstrb = 4'hF;
    // cycles 1..3: no further acceptance; response in cycle 3
    for (int i = 1; i <= 3; i++) begin
      if (i > 1) next_cycle();
      @(negedge clk);
      n_checks++; if (bus.data_addr_ok !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_c%0d: got %b want 0", i, bus.data_addr_ok); end
    end
    n_checks++; if (bus.data_data_ok !== 1'b1 || bus.data_rdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL b2b_read_resp: got ok=%b rdata=%h want 1/a5a50001", bus.data_data_ok, bus.data_rdata); end
    // cycle 4: next acceptance
    next_cycle();
    @(negedge clk);
    n_checks++; if (bus.data_addr_ok !== 1'b1 || bus.data_data_ok !== 1'b0) begin n_fail++; $display("FAIL b2b_second_grant: got addr_ok=%b data_ok=%b want 1/0", bus.data_addr_ok, bus.data_data_ok); end
    // cycle 5: AW_W both handshake
    next_cycle();
    bus.data_req = 0;
    @(negedge clk);
    n_checks++; if (bus.awvalid !== 1'b1 || bus.wvalid !== 1'b1 || bus.wdata !== 32'h0BAD_F00D || bus.awsize !== 3'd2) begin n_fail++; $display("FAIL b2b_aw_w: got aw=%b w=%b wdata=%h size=%h want 1/1/0badf00d/2", bus.awvalid, bus.wvalid, bus.wdata, bus.awsize); end
    // cycle 6: B, cycle 7: response; read data register untouched by the write
    next_cycle();
    next_cycle();
    @(negedge clk);
    n_checks++; if (bus.data_data_ok !== 1'b1 || bus.data_rdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL b2b_write_resp: got ok=%b rdata=%h want 1/a5a50001", bus.data_data_ok, bus.data_rdata); end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_inst_read();
    test_simultaneous();
    test_split_write();
    test_stalls();
    test_reset_mid_read();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_axi_bridge.md
# cpu_axi_bridge

Bus bridge sitting directly downstream of the CPU core. It accepts the core's two sram-like request ports, instruction and data, and arbitrates between them. It converts each accepted request into a single-beat AXI3 read or write on one shared master port. Only one transaction is outstanding at a time.

## Interface
- No parameters. The AXI ID width is 4, data width 32, address width 32; all are fixed.
- clk  in  1  single clock; all state updates on its rising edge.
- resetn  in  1  reset, asynchronous assert, active-low.
- inst_req, inst_wr  in  1 each  instruction-port request valid; write flag.
- inst_size  in  2  0=byte, 1=half, 2=word.
- inst_wstrb  in  4  byte enables.
- inst_addr, inst_wdata  in  32 each  address; write data.
- inst_addr_ok, inst_data_ok  out  1 each  request accepted; response ready.
- inst_rdata  out  32  read data.
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata, data_addr_ok, data_data_ok, data_rdata  same directions and widths as the inst_* set, for the data port.
- arid  out  4; araddr  out  32; arlen  out  8; arsize  out  3; arburst  out  2; arlock  out  2; arcache  out  4; arprot  out  3; arvalid  out  1; arready  in  1.
- rid  in  4; rdata  in  32; rresp  in  2; rlast  in  1; rvalid  in  1; rready  out  1.
- awid  out  4; awaddr  out  32; awlen  out  8; awsize  out  3; awburst  out  2; awlock  out  2; awcache  out  4; awprot  out  3; awvalid  out  1; awready  in  1.
- wid  out  4; wdata  out  32; wstrb  out  4; wlast  out  1; wvalid  out  1; wready  in  1.
- bid  in  4; bresp  in  2; bvalid  in  1; bready  out  1.

## Operation
- FSM states: IDLE, AR, R, AW_W, B, RESP. Reset value is IDLE.
- Arbitration happens only in IDLE:
  - Grant goes to data if data_req=1, else to inst if inst_req=1.
  - The granted port's addr_ok = 1, combinationally, in IDLE only. The other port's addr_ok = 0.
- Acceptance (req & addr_ok):
  - Latch wr, size, wstrb, addr, wdata and a source bit (0=inst, 1=data).
  - Next state is AR if wr=0, otherwise AW_W.
- AR state:
  - arvalid=1, araddr=latched addr, arsize={1'b0,size}, arid={3'b0,source}.
  - On arready, go to R.
- R state:
  - rready=1.
  - On rvalid, capture rdata into the response register and go to RESP. rid, rresp and rlast are ignored.
- AW_W state:
  - awvalid and wvalid start at 1 and are tracked by separate done flags.
  - Each valid drops after its own handshake, in either order or the same cycle.
  - When both are done, go to B.
  - awsize={1'b0,size}, wstrb=latched wstrb, awid=wid=4'd1.
- B state:
  - bready=1.
  - On bvalid, go to RESP. bid and bresp are ignored.
- RESP state:
  - The source port's data_ok=1 for exactly one cycle; the other port's data_ok=0.
  - {inst,data}_rdata = response register; it holds the value until the next read overwrites it.
  - For writes, rdata is don't-care.
  - Next state is IDLE.
- Constant outputs: arlen=awlen=0, arburst=awburst=2'b01, lock=0, cache=0, prot=0, wlast=1.
- Address and size pass through unmodified; the requester aligns them.

## Timing
- Reset state (async, resetn low):
  - state=IDLE.
  - All AXI valid/ready outputs = 0.
  - Both addr_ok and both data_ok = 0; addr_ok is gated by resetn.
  - Response register = 0.
- Minimum read latency with arready and rvalid held high:
  - Accept in cycle 0.
  - arvalid in cycle 1.
  - R in cycle 2 (rvalid sampled).
  - data_ok in cycle 3.
- Minimum write latency with awready=wready=bvalid=1:
  - Accept in cycle 0.
  - AW/W handshakes in cycle 1.
  - B in cycle 2.
  - data_ok in cycle 3.
- Handshake stability: while a valid is high and unacknowledged, every field on that channel is stable.
- Simultaneous inst_req and data_req: data wins. inst_req must be held and is granted on the next return to IDLE.
- Requests arriving while not in IDLE are not accepted (addr_ok=0). No request is lost while the requester keeps req high.
- Back-to-back throughput: the next acceptance can occur in the cycle after RESP, i.e. at most one transaction per 4 cycles.
- Reset mid-transaction aborts immediately. No data_ok is issued for the aborted request.

## Test plan
- Single inst read:
  - Stimulus: inst_req=1, addr=0x1C000000, size=2; arready=1; rvalid one cycle later with rdata=0x02800C0C.
  - Required: arid=0, arsize=2, arlen=0; inst_data_ok pulses once in cycle 3; inst_rdata=0x02800C0C.
- Simultaneous requests:
  - Stimulus: inst read 0x1C000004 and data read 0x00001000 both asserted in cycle 0.
  - Required: data_addr_ok=1 and inst_addr_ok=0 in cycle 0. Data AR (arid=1) is issued first; the inst AR follows after data_data_ok.
- Split write handshake:
  - Stimulus: data write addr=0x00002000, wdata=0xDEADBEEF, wstrb=0x3, size=1; wready asserted 3 cycles before awready.
  - Required: wvalid drops after its handshake while awvalid stays held; B is entered only after both; awsize=1, wstrb=0x3, wlast=1; a single data_data_ok pulse.
- AXI stalls:
  - Stimulus: arready low for 5 cycles, then rvalid delayed 4 cycles.
  - Required: arvalid held with araddr stable throughout; rready high only in R; no data_ok before rvalid.
- Reset mid-read:
  - Stimulus: resetn pulled low while in R.
  - Required: rready, arvalid and both data_ok drop to 0 immediately; after release the FSM is in IDLE and a new inst read completes normally.
